// File: rtl/fetch_pkg.sv
// Shared widths, reset PC default and FSM state type for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W  = 16;
    localparam int unsigned FETCH_INSTR_W = 16;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: loads either pc+1 (wrapping) or a redirect target.
module fetch_pc_reg #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic              sel_redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_next;

    always_comb begin
        pc_next = sel_redirect ? redirect_pc : pc + ADDR_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch sequencer: one outstanding imem request, valid/ready handoff to decode, branch redirects.
// FETCH_BYPASS_EN: forwards the memory response straight to decode while in WAIT.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    fetch_state_t       state;
    fetch_state_t       state_n;
    logic               drop;
    logic               drop_n;
    logic               pc_load;
    logic               pc_sel_redirect;
    logic               capture;
    logic [ADDR_W-1:0]  pc;
    logic               req_valid_q;
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_pc_q;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock        (clock),
        .reset_n      (reset_n),
        .load         (pc_load),
        .sel_redirect (pc_sel_redirect),
        .redirect_pc  (redirect_pc),
        .pc           (pc)
    );

    // Next-state, drop tracking and PC update control; redirect outranks everything.
    always_comb begin
        state_n         = state;
        drop_n          = drop;
        pc_load         = 1'b0;
        pc_sel_redirect = 1'b0;
        capture         = 1'b0;
        case (state)
            IDLE: begin
                state_n = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_load         = 1'b1;
                    pc_sel_redirect = 1'b1;
                    if (imem_req_ready) begin
                        drop_n  = 1'b1;
                        state_n = WAIT;
                    end
                end else if (imem_req_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_load         = 1'b1;
                    pc_sel_redirect = 1'b1;
                    if (imem_rsp_valid) begin
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        drop_n = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop) begin
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end
`ifdef FETCH_BYPASS_EN
                    else if (instr_ready) begin
                        pc_load = 1'b1;
                        state_n = REQ;
                    end
`endif
                    else begin
                        capture = 1'b1;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_load         = 1'b1;
                    pc_sel_redirect = 1'b1;
                    state_n         = REQ;
                end else if (instr_ready) begin
                    pc_load = 1'b1;
                    state_n = REQ;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            drop          <= 1'b0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state         <= state_n;
            drop          <= drop_n;
            req_valid_q   <= (state_n == REQ);
            instr_valid_q <= (state_n == HOLD);
            if (capture) begin
                instr_q    <= imem_rsp_data;
                instr_pc_q <= pc;
            end
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc;

`ifdef FETCH_BYPASS_EN
    // A live, non-dropped response is visible to decode in the same cycle it returns.
    logic bypass_hit;
    assign bypass_hit  = (state == WAIT) && imem_rsp_valid && !drop && !redirect_valid;
    assign instr_valid = instr_valid_q | bypass_hit;
    assign instr       = bypass_hit ? imem_rsp_data : instr_q;
    assign instr_pc    = bypass_hit ? pc : instr_pc_q;
`else
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch in its default (fully registered) build.
module tb_instruction_fetch;

    logic        clock;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    int checks;
    int errors;

    instruction_fetch dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0000;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;

        // Reset values
        #1;
        check("rst req_valid", 32'(imem_req_valid), 32'd0);
        check("rst instr_valid", 32'(instr_valid), 32'd0);
        check("rst instr", 32'(instr), 32'h0);
        check("rst instr_pc", 32'(instr_pc), 32'h0);
        check("rst imem_addr", 32'(imem_addr), 32'h0);
        step();
        step();
        reset_n = 1'b1;
        check("idle req_valid", 32'(imem_req_valid), 32'd0);
        step();
        check("first req_valid", 32'(imem_req_valid), 32'd1);

        // Zero-wait memory, decode always ready: PCs 0..4, three cycles each
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("seq%0d addr", i), 32'(imem_addr), 32'(i));
            check($sformatf("seq%0d req_valid", i), 32'(imem_req_valid), 32'd1);
            imem_req_ready = 1'b1;
            step();
            imem_req_ready = 1'b0;
            check($sformatf("seq%0d wait instr_valid", i), 32'(instr_valid), 32'd0);
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 16'hA000 + 16'(i);
            step();
            imem_rsp_valid = 1'b0;
            check($sformatf("seq%0d instr_valid", i), 32'(instr_valid), 32'd1);
            check($sformatf("seq%0d instr", i), 32'(instr), 32'hA000 + 32'(i));
            check($sformatf("seq%0d instr_pc", i), 32'(instr_pc), 32'(i));
            step();
        end

        // Memory stalls four cycles at 0005
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall%0d addr", i), 32'(imem_addr), 32'h0005);
            check($sformatf("stall%0d req_valid", i), 32'(imem_req_valid), 32'd1);
            step();
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'hB005;
        step();
        imem_rsp_valid = 1'b0;
        check("stall instr", 32'(instr), 32'hB005);
        check("stall instr_pc", 32'(instr_pc), 32'h0005);
        step();
        check("after stall addr", 32'(imem_addr), 32'h0006);

        // Redirect to 0040 while waiting; late 0xBEEF response must be dropped
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        step();
        redirect_valid = 1'b0;
        check("redir wait req_valid", 32'(imem_req_valid), 32'd0);
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'hBEEF;
        step();
        imem_rsp_valid = 1'b0;
        check("drop instr_valid", 32'(instr_valid), 32'd0);
        check("drop req_valid", 32'(imem_req_valid), 32'd1);
        check("drop addr", 32'(imem_addr), 32'h0040);
        step();
        check("drop stays invalid", 32'(instr_valid), 32'd0);

        // Decode stalls five cycles in HOLD, then redirect 0100 with handoff
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'hC040;
        instr_ready    = 1'b0;
        step();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d instr_valid", i), 32'(instr_valid), 32'd1);
            check($sformatf("hold%0d instr", i), 32'(instr), 32'hC040);
            check($sformatf("hold%0d instr_pc", i), 32'(instr_pc), 32'h0040);
            check($sformatf("hold%0d req_valid", i), 32'(imem_req_valid), 32'd0);
            step();
        end
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        check("handoff instr_valid", 32'(instr_valid), 32'd1);
        step();
        redirect_valid = 1'b0;
        check("post handoff instr_valid", 32'(instr_valid), 32'd0);
        check("post handoff addr", 32'(imem_addr), 32'h0100);
        check("post handoff req_valid", 32'(imem_req_valid), 32'd1);

        // Redirect in REQ without handshake to FFFF, then wrap to 0000
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        check("req redir addr", 32'(imem_addr), 32'hFFFF);
        check("req redir req_valid", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'hD0FF;
        step();
        imem_rsp_valid = 1'b0;
        check("wrap instr_pc", 32'(instr_pc), 32'hFFFF);
        check("wrap instr", 32'(instr), 32'hD0FF);
        step();
        check("wrap addr", 32'(imem_addr), 32'h0000);

        // Redirect coincident with request handshake: next response dropped
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        check("hs redir req_valid", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'hE000;
        step();
        imem_rsp_valid = 1'b0;
        check("hs redir instr_valid", 32'(instr_valid), 32'd0);
        check("hs redir addr", 32'(imem_addr), 32'h0200);
        check("hs redir req_valid again", 32'(imem_req_valid), 32'd1);

        // Response outside WAIT is ignored
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'h1111;
        step();
        imem_rsp_valid = 1'b0;
        check("stray rsp instr_valid", 32'(instr_valid), 32'd0);
        check("stray rsp req_valid", 32'(imem_req_valid), 32'd1);
        check("stray rsp addr", 32'(imem_addr), 32'h0200);

        // Asynchronous reset in WAIT, stale response during reset
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("async rst req_valid", 32'(imem_req_valid), 32'd0);
        check("async rst addr", 32'(imem_addr), 32'h0000);
        check("async rst instr", 32'(instr), 32'h0);
        check("async rst instr_pc", 32'(instr_pc), 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'h5151;
        step();
        imem_rsp_valid = 1'b0;
        reset_n        = 1'b1;
        check("restart idle req_valid", 32'(imem_req_valid), 32'd0);
        check("restart idle instr_valid", 32'(instr_valid), 32'd0);
        step();
        check("restart req_valid", 32'(imem_req_valid), 32'd1);
        check("restart addr", 32'(imem_addr), 32'h0000);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 16'hF000;
        step();
        imem_rsp_valid = 1'b0;
        check("restart instr", 32'(instr), 32'hF000);
        check("restart instr_pc", 32'(instr_pc), 32'h0000);
        step();
        check("restart next addr", 32'(imem_addr), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
